writeback_cache: RTL

WRITEBACK_CACHE -- requirements
Module: writeback_cache

---
 rtl/writeback_cache.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/writeback_cache.sv
// Direct-mapped write-back, write-allocate cache between a 32-bit CPU port and a 128-bit memory port.
// A line holds four 128-bit beats. Each beat slot is its own registered-read RAM.
module writeback_cache #(
  parameter int LINES          = 64,
  parameter int CPU_WIDTH      = 32,
  parameter int WORD_ADDR_BITS = 30,
  parameter int MEM_DATA_BITS  = 128
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cpu_req_valid,
  output logic                         cpu_req_ready,
  input  logic [WORD_ADDR_BITS-1:0]    cpu_req_addr,
  input  logic [CPU_WIDTH-1:0]         cpu_req_data,
  input  logic [CPU_WIDTH/8-1:0]       cpu_req_write,
  output logic                         cpu_resp_valid,
  output logic [CPU_WIDTH-1:0]         cpu_resp_data,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [WORD_ADDR_BITS-3:0]    mem_req_addr,
  output logic                         mem_req_rw,
  output logic                         mem_req_data_valid,
  input  logic                         mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0]     mem_req_data_bits,
  output logic [MEM_DATA_BITS/8-1:0]   mem_req_data_mask,
  input  logic                         mem_resp_valid,
  input  logic [MEM_DATA_BITS-1:0]     mem_resp_data
);

  localparam int IDX       = $clog2(LINES);
  localparam int TAG       = WORD_ADDR_BITS - 4 - IDX;
  localparam int WAB       = WORD_ADDR_BITS;
  localparam int LINE_BITS = 4 * MEM_DATA_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB_REQ,
    S_WB_DATA,
    S_FILL_REQ,
    S_FILL_DATA
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WAB-1:0]         r_addr;
  logic [CPU_WIDTH-1:0]   r_wdata;
  logic [CPU_WIDTH/8-1:0] r_wmask;
  logic [LINES-1:0]       r_valid;
  logic [LINES-1:0]       r_dirty;
  logic [1:0]             r_beat_cnt;
  logic [CPU_WIDTH-1:0]   r_resp_hold;

  logic [TAG-1:0]         r_tag_mem [LINES];
  logic [TAG-1:0]         r_tag_q;

  logic [TAG-1:0]         w_req_tag;
  logic [IDX-1:0]         w_req_idx;
  logic [1:0]             w_req_beat;
  logic [1:0]             w_req_word;
  logic [IDX-1:0]         w_in_idx;
  logic [LINE_BITS-1:0]   w_rd_line;
  logic [CPU_WIDTH-1:0]   w_sel_word;
  logic [MEM_DATA_BITS-1:0] w_merged_beat;

  logic w_ready;
  logic w_accept;
  logic w_hit;
  logic w_is_read;
  logic w_victim_dirty;
  logic w_resp_valid;
  logic w_wr_hit;
  logic w_wb_beat_go;
  logic w_fill_we;
  logic w_fill_done;
  logic w_mem_req_valid;
  logic w_mem_req_rw;
  logic [WAB-3:0] w_mem_req_addr;
  logic w_mem_data_valid;
  logic [MEM_DATA_BITS-1:0] w_mem_data_bits;

  assign w_req_tag  = r_addr[WAB-1:4+IDX];
  assign w_req_idx  = r_addr[3+IDX:4];
  assign w_req_beat = r_addr[3:2];
  assign w_req_word = r_addr[1:0];
  assign w_in_idx   = cpu_req_addr[3+IDX:4];

  assign w_hit          = r_valid[w_req_idx] && (r_tag_q == w_req_tag);
  assign w_is_read      = (r_wmask == '0);
  assign w_victim_dirty = r_valid[w_req_idx] && r_dirty[w_req_idx];
  assign w_sel_word     = w_rd_line[int'({w_req_beat, w_req_word}) * CPU_WIDTH +: CPU_WIDTH];

  assign w_accept     = cpu_req_valid && cpu_req_ready;
  assign w_wr_hit     = (r_state == S_LOOKUP) && w_hit && !w_is_read;
  assign w_wb_beat_go = (r_state == S_WB_DATA) && mem_req_data_ready;
  assign w_fill_we    = (r_state == S_FILL_DATA) && mem_resp_valid;
  assign w_fill_done  = w_fill_we && (r_beat_cnt == 2'd3);

  // Store merge: only the enabled bytes of the addressed word replace the cached beat.
  always_comb begin
    w_merged_beat = w_rd_line[int'(w_req_beat) * MEM_DATA_BITS +: MEM_DATA_BITS];
    for (int b = 0; b < CPU_WIDTH / 8; b++) begin
      if (r_wmask[b]) begin
        w_merged_beat[int'(w_req_word) * CPU_WIDTH + b * 8 +: 8] = r_wdata[b * 8 +: 8];
      end
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_ready          = 1'b0;
    w_resp_valid     = 1'b0;
    w_mem_req_valid  = 1'b0;
    w_mem_req_rw     = 1'b0;
    w_mem_req_addr   = '0;
    w_mem_data_valid = 1'b0;
    w_mem_data_bits  = '0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (cpu_req_valid) w_state_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (w_hit) begin
          if (w_is_read) begin
            w_resp_valid = 1'b1;
            w_ready      = 1'b1;
            w_state_next = cpu_req_valid ? S_LOOKUP : S_IDLE;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_state_next = w_victim_dirty ? S_WB_REQ : S_FILL_REQ;
        end
      end
      S_WB_REQ: begin
        w_mem_req_valid = 1'b1;
        w_mem_req_rw    = 1'b1;
        w_mem_req_addr  = {r_tag_q, w_req_idx, 2'b00};
        if (mem_req_ready) w_state_next = S_WB_DATA;
      end
      S_WB_DATA: begin
        w_mem_data_valid = 1'b1;
        w_mem_data_bits  = w_rd_line[int'(r_beat_cnt) * MEM_DATA_BITS +: MEM_DATA_BITS];
        if (mem_req_data_ready && (r_beat_cnt == 2'd3)) w_state_next = S_FILL_REQ;
      end
      S_FILL_REQ: begin
        w_mem_req_valid = 1'b1;
        w_mem_req_addr  = {w_req_tag, w_req_idx, 2'b00};
        if (mem_req_ready) w_state_next = S_FILL_DATA;
      end
      S_FILL_DATA: begin
        if (w_fill_done) w_state_next = S_LOOKUP;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Ready is gated by reset_n so the port is silent for the whole reset window.
  assign cpu_req_ready      = w_ready && reset_n;
  assign cpu_resp_valid     = w_resp_valid;
  assign cpu_resp_data      = w_resp_valid ? w_sel_word : r_resp_hold;
  assign mem_req_valid      = w_mem_req_valid;
  assign mem_req_rw         = w_mem_req_rw;
  assign mem_req_addr       = w_mem_req_addr;
  assign mem_req_data_valid = w_mem_data_valid;
  assign mem_req_data_bits  = w_mem_data_bits;
  assign mem_req_data_mask  = '1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_beat_cnt  <= '0;
      r_resp_hold <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_addr  <= cpu_req_addr;
        r_wdata <= cpu_req_data;
        r_wmask <= cpu_req_write;
      end
      if (w_resp_valid) r_resp_hold <= w_sel_word;
      if (w_wb_beat_go || w_fill_we) r_beat_cnt <= r_beat_cnt + 2'd1;
      if (w_wr_hit) r_dirty[w_req_idx] <= 1'b1;
      if (w_fill_done) begin
        r_valid[w_req_idx] <= 1'b1;
        r_dirty[w_req_idx] <= 1'b0;
      end
    end
  end

  // The read register also captures the new tag at fill completion so the re-lookup hits.
  always_ff @(posedge clk) begin
    if (w_fill_done) r_tag_mem[w_req_idx] <= w_req_tag;
    if (w_accept) r_tag_q <= r_tag_mem[w_in_idx];
    else if (w_fill_done) r_tag_q <= w_req_tag;
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_beat
      logic [MEM_DATA_BITS-1:0] r_mem [LINES];
      logic [MEM_DATA_BITS-1:0] r_rd_q;

      // Fill beats bypass into the read register; the victim copy stays intact until the fill.
      always_ff @(posedge clk) begin
        if (w_fill_we && (r_beat_cnt == 2'(gi))) r_mem[w_req_idx] <= mem_resp_data;
        else if (w_wr_hit && (w_req_beat == 2'(gi))) r_mem[w_req_idx] <= w_merged_beat;
        if (w_accept) r_rd_q <= r_mem[w_in_idx];
        else if (w_fill_we && (r_beat_cnt == 2'(gi))) r_rd_q <= mem_resp_data;
      end

      assign w_rd_line[gi * MEM_DATA_BITS +: MEM_DATA_BITS] = r_rd_q;
    end
  endgenerate

endmodule
